// File: rtl/rom_stream_reader.sv
// Start/length-driven read sequencer for the sample ROM. It hides the ROM's
// one-cycle read latency and streams words out through a 4-entry buffer.
module rom_stream_reader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              loop,
  input  logic              abort,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic                r_loop;
  logic [ADDR_W:0]     r_left;
  logic [ADDR_W-1:0]   r_next;
  logic                r_rom_en;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_p1;
  logic [ADDR_W-1:0]   r_a1;
  logic [DATA_W-1:0]   r_mem_d [4];
  logic [ADDR_W-1:0]   r_mem_a [4];
  logic [1:0]          r_wr_ptr;
  logic [1:0]          r_rd_ptr;
  logic [2:0]          r_count;

  logic [ADDR_W:0]     w_len_eff;
  logic [2:0]          w_in_flight;
  logic                w_room;
  logic                w_can_issue;
  logic                w_pop;

  // A zero length encodes a full sweep of the ROM.
  assign w_len_eff   = (length == '0) ? {1'b1, {ADDR_W{1'b0}}} : length;
  assign w_in_flight = {2'b00, r_rom_en} + {2'b00, r_p1};
  // Reads already issued but not yet buffered reserve a slot, so the buffer can never overflow.
  assign w_room      = (w_in_flight + r_count) < 3'(FIFO_DEPTH);
  assign w_can_issue = (r_state == S_RUN) && (r_left != '0) && w_room;
  assign w_pop       = (r_count != 3'd0) && m_ready;

  assign rom_en   = r_rom_en;
  assign rom_addr = r_rom_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign m_valid  = (r_count != 3'd0);
  assign m_data   = r_mem_d[r_rd_ptr];
  assign m_addr   = r_mem_a[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_loop     <= 1'b0;
      r_left     <= '0;
      r_next     <= '0;
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state  <= S_IDLE;
        r_rom_en <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_rom_en <= 1'b0;
            if (start) begin
              r_base     <= base_addr;
              r_len      <= w_len_eff;
              r_loop     <= loop;
              r_rom_en   <= 1'b1;
              r_rom_addr <= base_addr;
              r_busy     <= 1'b1;
              r_state    <= S_RUN;
              if (loop && (w_len_eff == {{ADDR_W{1'b0}}, 1'b1})) begin
                r_left <= w_len_eff;
                r_next <= base_addr;
              end else begin
                r_left <= w_len_eff - {{ADDR_W{1'b0}}, 1'b1};
                r_next <= base_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              end
            end
          end
          S_RUN: begin
            if (w_can_issue) begin
              r_rom_en   <= 1'b1;
              r_rom_addr <= r_next;
              // Loop mode reloads on the last issue so the stream has no bubble.
              if (r_loop && (r_left == {{ADDR_W{1'b0}}, 1'b1})) begin
                r_left <= r_len;
                r_next <= r_base;
              end else begin
                r_left <= r_left - {{ADDR_W{1'b0}}, 1'b1};
                r_next <= r_next + {{(ADDR_W-1){1'b0}}, 1'b1};
              end
            end else begin
              r_rom_en <= 1'b0;
              if (!r_loop && (r_left == '0)) begin
                r_state <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            r_rom_en <= 1'b0;
            if ((w_in_flight == 3'd0) && (r_count == 3'd0)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if ((w_in_flight == 3'd0) && (r_count == 3'd1) && w_pop) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_rom_en <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Tracks each read through the ROM latency and buffers the returned word with its address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p1     <= 1'b0;
      r_a1     <= '0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        r_mem_d[i] <= '0;
        r_mem_a[i] <= '0;
      end
    end else if (abort) begin
      r_p1     <= 1'b0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      r_p1 <= r_rom_en;
      r_a1 <= r_rom_addr;
      if (r_p1) begin
        r_mem_d[r_wr_ptr] <= rom_data;
        r_mem_a[r_wr_ptr] <= r_a1;
        r_wr_ptr          <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_count <= r_count + {2'b00, r_p1} - {2'b00, w_pop};
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a ROM model and an expected-word queue.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] base_addr = 9'd0;
  logic [9:0] length = 10'd0;
  logic       loop = 1'b0;
  logic       abort = 1'b0;
  logic       rom_en;
  logic [8:0] rom_addr;
  logic [7:0] rom_data = 8'd0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [8:0] m_addr;
  logic       busy;
  logic       done;

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   outs    = 0;

  rom_stream_reader #(.ADDR_W(9), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .loop(loop), .abort(abort), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_addr(m_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with a one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= rom_addr[7:0] ^ 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_xfer(input logic [8:0] b, input int n, input bit with_last);
    exp_t e;
    logic [8:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 9'(i);
      e.addr = a;
      e.data = a[7:0] ^ 8'hA5;
      e.last = with_last && (i == n - 1);
      sb.push_back(e);
    end
  endtask

  // One clock: handshake sampled before the edge, checks after it.
  task automatic tick();
    logic       pv, pr, pab, hs, lastpop;
    logic [7:0] pd;
    logic [8:0] pa;
    exp_t       e;
    pv = m_valid; pr = m_ready; pd = m_data; pa = m_addr; pab = abort;
    hs = pv && pr;
    lastpop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (hs) begin
      if (sb.size() == 0) begin
        chk("extra_word", {23'd0, pa}, 32'h0dead);
      end else begin
        e = sb.pop_front();
        chk("m_addr", {23'd0, pa}, {23'd0, e.addr});
        chk("m_data", {24'd0, pd}, {24'd0, e.data});
        lastpop = e.last;
        outs--;
      end
    end
    if (pab) begin
      sb.delete();
      outs = 0;
      chk("abort_valid", {31'd0, m_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
    end else begin
      chk("done", {31'd0, done}, {31'd0, lastpop});
      if (lastpop) chk("busy_after_done", {31'd0, busy}, 32'd0);
      if (pv && !pr) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", {24'd0, m_data}, {24'd0, pd});
        chk("stall_addr", {23'd0, m_addr}, {23'd0, pa});
      end
      if (rom_en) outs++;
      chk("outstanding_le4", {31'd0, (outs <= 4)}, 32'd1);
    end
  endtask

  task automatic wait_empty(input int budget, input bit toggle);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      if (toggle) m_ready = (k % 3 == 0);
      tick();
      k++;
    end
    m_ready = 1'b1;
    if (sb.size() != 0) chk("timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_start(input logic [8:0] b, input logic [9:0] len, input logic lp);
    base_addr = b; length = len; loop = lp; start = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b1;
    tick();

    // Basic transfer and latency.
    do_start(9'h010, 10'd4, 1'b0);
    push_xfer(9'h010, 4, 1'b1);
    tick(); start = 1'b0;
    chk("lat_rom_en", {31'd0, rom_en}, 32'd1);
    chk("lat_rom_addr", {23'd0, rom_addr}, 32'h010);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("lat_valid1", {31'd0, m_valid}, 32'd0);
    tick();
    chk("lat_valid2", {31'd0, m_valid}, 32'd0);
    tick();
    chk("lat_valid3", {31'd0, m_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("burst_valid", {31'd0, m_valid}, 32'd1);
      tick();
    end
    chk("burst_empty", 32'(sb.size()), 32'd0);
    tick();

    // Same transfer with back-pressure.
    do_start(9'h010, 10'd4, 1'b0);
    push_xfer(9'h010, 4, 1'b1);
    tick(); start = 1'b0;
    wait_empty(60, 1'b1);
    tick();

    // Address wrap.
    do_start(9'h1FE, 10'd4, 1'b0);
    push_xfer(9'h1FE, 4, 1'b1);
    tick(); start = 1'b0;
    wait_empty(30, 1'b0);
    tick();

    // Full sweep.
    do_start(9'h000, 10'd0, 1'b0);
    push_xfer(9'h000, 512, 1'b1);
    tick(); start = 1'b0;
    wait_empty(700, 1'b0);
    tick(); tick();
    chk("sweep_busy", {31'd0, busy}, 32'd0);

    // Loop mode, then abort together with the 8th handshake.
    do_start(9'd5, 10'd3, 1'b1);
    push_xfer(9'd5, 3, 1'b0);
    push_xfer(9'd5, 3, 1'b0);
    push_xfer(9'd5, 2, 1'b0);
    tick(); start = 1'b0; loop = 1'b0;
    begin
      int  k = 0;
      bit  seen = 1'b0;
      while (sb.size() > 1 && k < 40) begin
        if (seen) chk("loop_no_gap", {31'd0, m_valid}, 32'd1);
        if (m_valid) seen = 1'b1;
        tick();
        k++;
      end
    end
    chk("loop_valid_pre", {31'd0, m_valid}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_rom_en", {31'd0, rom_en}, 32'd0);
    end

    // start while busy is ignored.
    do_start(9'h010, 10'd4, 1'b0);
    push_xfer(9'h010, 4, 1'b1);
    tick();
    do_start(9'h080, 10'd2, 1'b0);
    tick(); start = 1'b0;
    wait_empty(30, 1'b0);
    tick(); tick();

    // start and abort together in IDLE.
    do_start(9'h040, 10'd4, 1'b0);
    abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("start_abort_rom_en", {31'd0, rom_en}, 32'd0);
      chk("start_abort_busy", {31'd0, busy}, 32'd0);
    end

    // Reset mid-transfer with two words buffered.
    m_ready = 1'b0;
    do_start(9'h020, 10'd8, 1'b0);
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_rom_en", {31'd0, rom_en}, 32'd0);
    chk("mid_rst_rom_addr", {23'd0, rom_addr}, 32'd0);
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    chk("mid_rst_m_addr", {23'd0, m_addr}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    sb.delete();
    outs = 0;
    m_ready = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rom_en", {31'd0, rom_en}, 32'd0);
    end
    do_start(9'h100, 10'd1, 1'b0);
    push_xfer(9'h100, 1, 1'b1);
    tick(); start = 1'b0;
    wait_empty(20, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
